// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Fetch sequencer for a byte-wide instruction memory. Holds the program
// counter and reads each 32-bit instruction one byte per cycle over four
// cycles through the memory's combinational byte port. The bytes are packed
// little-endian into an assembly register, and the instruction is then
// offered to decode with a valid/ready handshake. Execute-stage redirects are
// accepted in every state and take priority over everything else.
//
// Parameters:
//   PC_W      program counter width
//   MEM_AW    byte-address width of the instruction memory
//   RESET_PC  PC value loaded on reset
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   reset_n         asynchronous active-low reset
//   mem_addr        byte address to instruction memory (pc + byte index, wraps)
//   mem_rdata       byte returned combinationally for mem_addr
//   redirect_valid  load redirect_pc as the new PC this cycle
//   redirect_pc     redirect target
//   inst_valid      inst / inst_pc are valid for decode
//   inst_ready      decode accepts the instruction
//   inst            assembled instruction
//   inst_pc         address of inst
//   fetch_cnt       instructions accepted since reset (wraps at 2^32)
//   fault           misaligned-PC fault
//
// Optional feature: define IMEM_MISALIGN_TRAP_EN to trap on a PC whose two
// low bits are non-zero. Without it a misaligned PC is fetched byte-wise as
// is and fault stays 0.
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int              PC_W     = 64,
    parameter int              MEM_AW   = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [31:0]       fetch_cnt,
    output logic              fault
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     asm_q, asm_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic            fault_q, fault_d;
    logic            trap_req;

    // Byte address wraps modulo the memory size, so a PC near the top of
    // memory continues at address 0.
    assign mem_addr = pc_q[MEM_AW-1:0] + MEM_AW'(bcnt_q);

    // The misalignment check is made only before the first byte is read.
`ifdef IMEM_MISALIGN_TRAP_EN
    assign trap_req = (bcnt_q == 2'd0) && (pc_q[1:0] != 2'b00);
`else
    assign trap_req = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        bcnt_d       = bcnt_q;
        asm_d        = asm_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        fault_d      = fault_q;

        case (state_q)
            FETCH: begin
                if (trap_req) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    asm_d[{bcnt_q, 3'b000} +: 8] = mem_rdata;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d      = VALID;
                        inst_valid_d = 1'b1;
                        inst_pc_d    = pc_q;
                    end
                end
            end
            VALID: begin
                if (inst_ready) begin
                    pc_d         = pc_q + PC_W'(4);
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    bcnt_d       = 2'd0;
                    state_d      = FETCH;
                    inst_valid_d = 1'b0;
                end
            end
            FAULT: begin
                // Only a redirect (below) or reset leaves this state.
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect overrides the next PC and state, but a handshake in the
        // same cycle has already been counted above and is kept. The partial
        // assembly register is left untouched; its lanes are refilled from
        // the new target before it is presented again.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            bcnt_d       = 2'd0;
            state_d      = FETCH;
            fault_d      = 1'b0;
            inst_valid_d = 1'b0;
            asm_d        = asm_q;
            inst_pc_d    = inst_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            bcnt_q       <= 2'd0;
            asm_q        <= 32'd0;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            fault_q      <= fault_d;
        end
    end

    assign inst       = asm_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Self-checking bench for imem_fetch_ctrl. A 16-byte memory model answers
// mem_addr combinationally. Expected instructions are queued as stimulus is
// issued; a monitor pops and compares one entry on every handshake. Cycle
// level properties (latency, stalls, counters, addresses) are compared
// against hand-computed constants in the stimulus thread.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [31:0] fetch_cnt;
    logic        fault;

    logic [7:0]  mem [16];
    exp_t        sb[$];
    int          checks;
    int          errors;

    imem_fetch_ctrl #(
        .PC_W    (64),
        .MEM_AW  (4),
        .RESET_PC(64'd0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .fetch_cnt     (fetch_cnt),
        .fault         (fault)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
    endtask

    task automatic pushExpected(input logic [31:0] i, input logic [63:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("mon_unexpected_inst", {32'd0, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("mon_inst", {32'd0, inst}, {32'd0, e.inst});
                    checkOutput("mon_inst_pc", inst_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b0, 64'd0, 1'b1);
        mem[0] = 8'h83;
        mem[1] = 8'h34;
        mem[2] = 8'h85;
        mem[3] = 8'h02;
        for (int i = 4; i < 16; i++) mem[i] = 8'h10 + 8'(i);

        // Reset state
        #2;
        checkOutput("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        checkOutput("rst_inst", {32'd0, inst}, 64'd0);
        checkOutput("rst_inst_pc", inst_pc, 64'd0);
        checkOutput("rst_fetch_cnt", {32'd0, fetch_cnt}, 64'd0);
        checkOutput("rst_fault", {63'd0, fault}, 64'd0);
        checkOutput("rst_mem_addr", {60'd0, mem_addr}, 64'd0);

        // First fetch from address 0
        @(negedge clk);
        reset_n = 1'b1;
        pushExpected(32'h0285_3483, 64'd0);
        repeat (3) tick();
        checkOutput("first_valid_early", {63'd0, inst_valid}, 64'd0);
        tick();
        checkOutput("first_valid_rise", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("first_fetch_cnt", {32'd0, fetch_cnt}, 64'd1);
        checkOutput("first_next_addr", {60'd0, mem_addr}, 64'd4);
        checkOutput("first_valid_drop", {63'd0, inst_valid}, 64'd0);

        // Backpressure on the instruction at 4
        applyStimulus(1'b0, 64'd0, 1'b0);
        pushExpected(32'h1716_1514, 64'd4);
        repeat (4) tick();
        checkOutput("bp_valid", {63'd0, inst_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_hold_valid", {63'd0, inst_valid}, 64'd1);
            checkOutput("bp_hold_inst", {32'd0, inst}, 64'h1716_1514);
            checkOutput("bp_hold_pc", inst_pc, 64'd4);
            checkOutput("bp_hold_addr", {60'd0, mem_addr}, 64'd4);
            checkOutput("bp_hold_cnt", {32'd0, fetch_cnt}, 64'd1);
        end
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOutput("bp_release_cnt", {32'd0, fetch_cnt}, 64'd2);
        checkOutput("bp_release_valid", {63'd0, inst_valid}, 64'd0);

        // Instruction at 8, then partial fetch at 12 cut by redirect to 8
        pushExpected(32'h1B1A_1918, 64'd8);
        repeat (4) tick();
        checkOutput("pc8_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("pc8_cnt", {32'd0, fetch_cnt}, 64'd3);
        repeat (2) tick();
        checkOutput("mid_addr_bcnt2", {60'd0, mem_addr}, 64'd14);
        applyStimulus(1'b1, 64'd8, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("redir_addr", {60'd0, mem_addr}, 64'd8);
        checkOutput("redir_valid_low", {63'd0, inst_valid}, 64'd0);
        pushExpected(32'h1B1A_1918, 64'd8);
        repeat (3) tick();
        checkOutput("redir_valid_early", {63'd0, inst_valid}, 64'd0);
        tick();
        checkOutput("redir_valid_rise", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("redir_cnt", {32'd0, fetch_cnt}, 64'd4);

        // Redirect to 0 colliding with the handshake of the instruction at 12
        pushExpected(32'h1F1E_1D1C, 64'd12);
        repeat (4) tick();
        checkOutput("coll_valid", {63'd0, inst_valid}, 64'd1);
        applyStimulus(1'b1, 64'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("coll_cnt", {32'd0, fetch_cnt}, 64'd5);
        checkOutput("coll_addr", {60'd0, mem_addr}, 64'd0);
        checkOutput("coll_valid_low", {63'd0, inst_valid}, 64'd0);
        pushExpected(32'h0285_3483, 64'd0);
        repeat (4) tick();
        checkOutput("coll_next_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("coll_next_cnt", {32'd0, fetch_cnt}, 64'd6);

`ifndef IMEM_MISALIGN_TRAP_EN
        // Address wrap: PC 14 reads bytes 14,15,0,1
        applyStimulus(1'b1, 64'd14, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        pushExpected(32'h3483_1F1E, 64'd14);
        checkOutput("wrap_addr0", {60'd0, mem_addr}, 64'd14);
        tick();
        checkOutput("wrap_addr1", {60'd0, mem_addr}, 64'd15);
        tick();
        checkOutput("wrap_addr2", {60'd0, mem_addr}, 64'd0);
        tick();
        checkOutput("wrap_addr3", {60'd0, mem_addr}, 64'd1);
        checkOutput("wrap_fault", {63'd0, fault}, 64'd0);
        tick();
        checkOutput("wrap_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("wrap_cnt", {32'd0, fetch_cnt}, 64'd7);
`else
        // Misaligned PC 2 traps; redirect to 4 recovers
        applyStimulus(1'b1, 64'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("trap_fault_n1", {63'd0, fault}, 64'd0);
        tick();
        checkOutput("trap_fault_n2", {63'd0, fault}, 64'd1);
        checkOutput("trap_valid_n2", {63'd0, inst_valid}, 64'd0);
        repeat (3) tick();
        checkOutput("trap_fault_hold", {63'd0, fault}, 64'd1);
        checkOutput("trap_valid_hold", {63'd0, inst_valid}, 64'd0);
        applyStimulus(1'b1, 64'd4, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("trap_clear", {63'd0, fault}, 64'd0);
        pushExpected(32'h1716_1514, 64'd4);
        repeat (3) tick();
        checkOutput("trap_rec_early", {63'd0, inst_valid}, 64'd0);
        tick();
        checkOutput("trap_rec_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("trap_rec_cnt", {32'd0, fetch_cnt}, 64'd7);
`endif

        // Asynchronous reset mid-fetch (bcnt = 1), between clock edges
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", {63'd0, inst_valid}, 64'd0);
        checkOutput("arst_cnt", {32'd0, fetch_cnt}, 64'd0);
        checkOutput("arst_addr", {60'd0, mem_addr}, 64'd0);
        checkOutput("arst_inst", {32'd0, inst}, 64'd0);
        checkOutput("arst_inst_pc", inst_pc, 64'd0);
        reset_n = 1'b1;
        pushExpected(32'h0285_3483, 64'd0);
        repeat (3) tick();
        checkOutput("arst_resume_early", {63'd0, inst_valid}, 64'd0);
        tick();
        checkOutput("arst_resume_valid", {63'd0, inst_valid}, 64'd1);
        tick();
        checkOutput("arst_resume_cnt", {32'd0, fetch_cnt}, 64'd1);

        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the single-cycle core's byte-wide instruction memory. Keeps the PC and reads the four bytes of each instruction over four cycles through the memory's combinational byte port. Assembles them little-endian into a 32-bit instruction and hands it to the decode stage with a valid/ready handshake. Accepts branch/jump redirects from the execute stage at any time.

## Interface
- `PC_W`, 64: program counter width.
- `MEM_AW`, 4: byte-address width of the instruction memory (16 bytes by default).
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `mem_addr`  out  MEM_AW  byte address presented to instruction memory.
- `mem_rdata`  in  8  byte returned combinationally for `mem_addr`.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  PC_W  redirect target.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  assembled instruction.
- `inst_pc`  out  PC_W  address of `inst`.
- `fetch_cnt`  out  32  number of instructions accepted since reset; wraps modulo 2^32.
- `fault`  out  1  misaligned-PC fault; see Configuration.

## Operation
- **State:** `pc`, a 2-bit byte counter `bcnt`, a 32-bit assembly register, and an FSM with states FETCH, VALID and FAULT.
- **Reset values:**
  - State FETCH, `pc`=RESET_PC, `bcnt`=0.
  - `inst`=0, `inst_pc`=RESET_PC, `inst_valid`=0, `fetch_cnt`=0, `fault`=0.
- **`mem_addr` (combinational):** `pc[MEM_AW-1:0] + bcnt`, truncated to MEM_AW bits, so it wraps modulo 2^MEM_AW. It is driven in every state; it is only meaningful in FETCH.
- **FETCH:**
  - Each cycle, `mem_rdata` is written to byte lane `bcnt` of the assembly register (bits `8*bcnt+7 : 8*bcnt`), and `bcnt` increments.
  - The cycle that captures `bcnt`=3 moves the FSM to VALID and sets `inst_pc`=`pc`.
  - `inst` always reflects the assembly register.
- **VALID:**
  - `inst_valid`=1.
  - `inst` and `inst_pc` hold stable until the handshake (`inst_valid & inst_ready`).
  - On the handshake: `pc` <= `pc`+4 (modulo 2^PC_W), `fetch_cnt` increments, `bcnt` <= 0, and the FSM returns to FETCH.
- **FAULT:** entered only when the feature is enabled (see Configuration). `fault`=1 and `inst_valid`=0. The FSM stays in FAULT until a redirect.
- **Redirect (highest priority, any state):**
  - `pc` <= `redirect_pc`, `bcnt` <= 0, state <= FETCH, `fault` <= 0.
  - Any partially assembled instruction is discarded.
  - If a handshake occurs in the same cycle, it still counts (`fetch_cnt` increments), but the next PC is `redirect_pc`, not `pc`+4.
- `inst_ready` is ignored when `inst_valid`=0.

## Timing
- Latency from entering FETCH to `inst_valid`=1 is 4 cycles: `inst_valid` rises on the edge after the fourth byte is captured.
- Maximum throughput is one instruction per 5 cycles (4 fetch cycles plus 1 VALID cycle) with `inst_ready` held at 1.
- A redirect asserted in cycle N causes the first byte read of the target in cycle N+1. `inst_valid` is 0 from N+1 and returns to 1 at N+5 at the earliest.
- `inst_valid` never drops without a handshake, except on a redirect.
- Asserting `reset_n` low at any point, including mid-fetch, immediately forces all reset values asynchronously. Fetching resumes at RESET_PC on the first edge after deassertion.

## Configuration
- Macro: `IMEM_MISALIGN_TRAP_EN`.
- **Defined:** while in FETCH with `bcnt`=0, if `pc[1:0]`≠0, no byte is captured and the next state is FAULT, with `fault`=1 from the next cycle. A redirect is the only exit (besides reset).
- **Undefined:** no FAULT state and `fault` is tied to 0. A misaligned PC is fetched byte-wise as-is, with address wrap as specified above.

## Test plan
- **Reset and first fetch:** the bench memory holds bytes 0–3 = 83,34,85,02. Release reset with `inst_ready`=1. Required: `inst_valid` rises 4 cycles after the first edge, with `inst`=0x02853483 and `inst_pc`=0. On the handshake, `fetch_cnt`=1 and `pc`=4.
- **Backpressure:** hold `inst_ready`=0 for 10 cycles while `inst_valid`=1. Required: `inst`, `inst_pc` and `mem_addr` stay stable and `fetch_cnt` does not change. Raising `inst_ready` completes exactly one handshake.
- **Redirect mid-fetch and collision:**
  - Assert `redirect_valid` with `redirect_pc`=8 when `bcnt`=2. Required: the next `inst` has `inst_pc`=8, built from bytes 8–11, with no instruction from the old PC delivered.
  - Assert a redirect to 0 in the same cycle as a handshake. Required: `fetch_cnt` increments and the next `inst_pc`=0.
- **Address wrap:** with MEM_AW=4, redirect to PC 14 with the macro undefined. Required: `mem_addr` sequence 14,15,0,1, and `inst` = {byte1,byte0,byte15,byte14}.
- **Misaligned PC trap:** with `IMEM_MISALIGN_TRAP_EN` defined, redirect to PC 2. Required: `fault`=1 from the next-but-one cycle and `inst_valid` stays 0. A redirect to 4 clears `fault`, and the instruction at 4 is delivered 4 cycles later.
- **Async reset mid-fetch:** pull `reset_n` low when `bcnt`=1 and between clock edges. Required: `inst_valid`=0, `fetch_cnt`=0 and `pc`=RESET_PC take effect immediately, with no clock edge needed.
